pong_frame_renderer: RTL and testbench
======================================

PONG_FRAME_RENDERER -- requirements
Module: pong_frame_renderer

Interface
REQ-001 Parameters SHALL be: XRES default 640 (active width); YRES default 480 (active height); BALL default 8 (square ball side, px); PAD_H default 64 (paddle height); PAD_SPD default 4 (px/frame); BALL_SPD default 2 (px/frame per axis); SERVE_FRAMES default 60 (serve hold).
REQ-002 clock  in  1  system clock; the only clock in the block.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 xpos, ypos  in  10 each  pixel coordinates from the CRT timing controller.
REQ-005 hsync_in, vsync_in  in  1 each  active-low timing syncs from the CRT timing controller.
REQ-006 p1_up, p1_down, p2_up, p2_down  in  1 each  debounced, clock-synchronous, active-high paddle buttons.
REQ-007 rgb  out  8  pixel colour, {R[2:0],G[2:0],B[1:0]}.
REQ-008 hsync, vsync  out  1 each  hsync_in/vsync_in delayed to align with rgb.
REQ-009 score1, score2  out  4 each  player scores, 0..9.
REQ-010 game_over  out  1  high while in GAMEOVER.

Function
REQ-011 rgb, hsync and vsync SHALL all be registered with exactly 1 clock latency from xpos/ypos/hsync_in/vsync_in.
REQ-012 frame_tick SHALL be a one-clock pulse on each falling edge of vsync_in; all game state SHALL update only on frame_tick.
REQ-013 Pixel priority: outside xpos<XRES && ypos<YRES -> 8'h00; ball (hidden in GAMEOVER) -> 8'hFF; paddle -> 8'h1C; centre line (xpos 319..320, ypos[4]==0) -> 8'h92; otherwise 8'h00.
REQ-014 Left paddle SHALL occupy x 16..23, right paddle x 616..623; paddle top y SHALL range 0..YRES-PAD_H (416).
REQ-015 Per frame_tick: up alone SHALL subtract PAD_SPD, down alone add PAD_SPD, clamped to range; both or neither -> no move.
REQ-016 Ball top-left (bx,by) SHALL range bx 0..XRES-BALL, by 0..YRES-BALL; direction bits dx (1=right), dy (1=down).
REQ-017 FSM states SHALL be SERVE, PLAY, POINT, GAMEOVER.
REQ-018 SERVE: ball at (316,236), counter increments per frame_tick; after SERVE_FRAMES ticks -> PLAY with counter cleared.
REQ-019 PLAY vertical: moving up with by<BALL_SPD -> by=0, dy=1; moving down with by>YRES-BALL-BALL_SPD -> by=472, dy=0; else by +/- BALL_SPD.
REQ-020 PLAY left face: moving left, bx>=24, bx-BALL_SPD<24, and by+BALL>padtop1 && by<padtop1+PAD_H -> bx=24, dx=1.
REQ-021 PLAY right face: moving right, bx+BALL<=616, bx+BALL+BALL_SPD>616, same overlap test on paddle 2 -> bx=608, dx=0.
REQ-022 PLAY miss: moving left with bx<BALL_SPD -> player 2 scores; moving right with bx>XRES-BALL-BALL_SPD -> player 1 scores; either -> POINT.
REQ-023 Paddle hit SHALL take precedence over miss on the same tick; vertical and horizontal rules SHALL apply together on one tick.
REQ-024 POINT (one frame_tick): increment scorer's score; if new score is 9 -> GAMEOVER, else -> SERVE with dx pointing toward the player who conceded, dy unchanged.
REQ-025 GAMEOVER SHALL hold scores, hide ball, allow paddle movement, and exit only via reset.
REQ-026 Paddle and ball arithmetic SHALL use 11-bit signed-safe intermediates; no wrap-around at 0 or limits.

Reset
REQ-027 With reset low at a clock edge: state SERVE, counter 0, ball (316,236), dx=1, dy=1, both paddle tops 208, scores 0, game_over 0, rgb 8'h00, hsync 1, vsync 1, frame-edge detector primed to vsync_in high.
REQ-028 Reset mid-frame or mid-game SHALL take effect on the next edge irrespective of state.

Configuration
REQ-029 With PONG_AUTO_PADDLE_EN defined, paddle 2 SHALL ignore p2_up/p2_down and move PAD_SPD per frame_tick toward aligning its centre with the ball centre (no move when within PAD_SPD), clamped; without it, paddle 2 SHALL follow REQ-015 using p2 buttons.

Verification
REQ-030 Reset release, sweep xpos/ypos -> rgb 8'hFF at (316..323,236..243) one clock later, 8'h1C at (16,208), 8'h00 at (700,100); hsync/vsync equal inputs delayed one clock.
REQ-031 Hold p1_up 60 frames from top 208 -> top reaches 0 after 52 frames, stays 0; p1_up+p1_down together -> no move.
REQ-032 60 frame_ticks after reset -> PLAY; next tick ball at (318,238).
REQ-033 Force ball toward top wall at by=1, dy=0 -> next tick by=0, dy=1.
REQ-034 Ball moving left at bx=25 with paddle1 overlapping -> bx=24, dx=1; without overlap, ball continues, score2 becomes 1 on reaching bx<2, state SERVE, dx=0.
REQ-035 Nine player-1 points -> score1=9, game_over=1, ball not drawn; reset low one clock -> all outputs at REQ-027 values.

Source files
------------

// File: rtl/pong_frame_renderer_if.sv
// Bundle between the CRT timing controller / button block (master) and the Pong renderer (slave).
interface pong_frame_renderer_if;
   logic [9:0] xpos;
   logic [9:0] ypos;
   logic       hsync_in;
   logic       vsync_in;
   logic       p1_up;
   logic       p1_down;
   logic       p2_up;
   logic       p2_down;
   logic [7:0] rgb;
   logic       hsync;
   logic       vsync;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       game_over;

   modport master (
      output xpos, ypos, hsync_in, vsync_in, p1_up, p1_down, p2_up, p2_down,
      input  rgb, hsync, vsync, score1, score2, game_over
   );

   modport slave (
      input  xpos, ypos, hsync_in, vsync_in, p1_up, p1_down, p2_up, p2_down,
      output rgb, hsync, vsync, score1, score2, game_over
   );
endinterface

// File: rtl/pong_frame_renderer.sv
// Pong game state (updated once per frame) plus a one-clock registered pixel generator.
// Define PONG_AUTO_PADDLE_EN to make paddle 2 track the ball instead of following the p2 buttons.
module pong_frame_renderer #(
   parameter int XRES         = 640,
   parameter int YRES         = 480,
   parameter int BALL         = 8,
   parameter int PAD_H        = 64,
   parameter int PAD_SPD      = 4,
   parameter int BALL_SPD     = 2,
   parameter int SERVE_FRAMES = 60
) (
   input logic                  clock,
   input logic                  reset,
   pong_frame_renderer_if.slave bus
);

   localparam int CW = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;

   localparam logic signed [10:0] XRES_S   = 11'(XRES);
   localparam logic signed [10:0] YRES_S   = 11'(YRES);
   localparam logic signed [10:0] BALL_S   = 11'(BALL);
   localparam logic signed [10:0] PADH_S   = 11'(PAD_H);
   localparam logic signed [10:0] PSPD_S   = 11'(PAD_SPD);
   localparam logic signed [10:0] BSPD_S   = 11'(BALL_SPD);
   localparam logic signed [10:0] BXMAX_S  = 11'(XRES - BALL);
   localparam logic signed [10:0] BYMAX_S  = 11'(YRES - BALL);
   localparam logic signed [10:0] PMAX_S   = 11'(YRES - PAD_H);
   localparam logic signed [10:0] PINIT_S  = 11'((YRES - PAD_H) / 2);
   localparam logic signed [10:0] SX_S     = 11'(XRES / 2 - BALL / 2);
   localparam logic signed [10:0] SY_S     = 11'(YRES / 2 - BALL / 2);
   localparam logic signed [10:0] LPADX0_S = 11'(16);
   localparam logic signed [10:0] LPADX1_S = 11'(23);
   localparam logic signed [10:0] RPADX0_S = 11'(XRES - 24);
   localparam logic signed [10:0] RPADX1_S = 11'(XRES - 17);
   localparam logic signed [10:0] LFACE_S  = 11'(24);
   localparam logic signed [10:0] RHIT_S   = 11'(XRES - 24 - BALL);
   localparam logic signed [10:0] CL0_S    = 11'(XRES / 2 - 1);
   localparam logic signed [10:0] CL1_S    = 11'(XRES / 2);

   typedef enum logic [1:0] {SERVE, PLAY, POINT, GAMEOVER} state_t;

   state_t          state, state_next;
   logic [CW-1:0]   counter, counter_next;
   logic [9:0]      bx, by, bx_next, by_next;
   logic            dx, dy, dx_next, dy_next;
   logic [9:0]      pad1, pad2, pad1_next, pad2_next;
   logic [3:0]      score1, score2, score1_next, score2_next, new_score;
   logic            vs_prev, frame_tick;
   logic [7:0]      rgb, pixel;
   logic            hsync, vsync;
   logic signed [10:0] bxs, bys, p1s, p2s, xs, ys, bx_step, by_step;
   logic            ov1, ov2, hit1, hit2, miss;
   logic            in_act, on_ball, on_pad, on_line;

   function automatic logic [9:0] pad_step(input logic [9:0] top, input logic up, input logic down);
      logic signed [10:0] t;
      t = {1'b0, top};
      if (up && !down)
         t = t - PSPD_S;
      else if (down && !up)
         t = t + PSPD_S;
      if (t < 11'sd0)
         t = 11'sd0;
      else if (t > PMAX_S)
         t = PMAX_S;
      return t[9:0];
   endfunction

   assign frame_tick = vs_prev & ~bus.vsync_in;
   assign bxs = {1'b0, bx};
   assign bys = {1'b0, by};
   assign p1s = {1'b0, pad1};
   assign p2s = {1'b0, pad2};

   // Miss keeps dx untouched, so in POINT dx names the scorer and already points at the conceder.
   always_comb begin
      state_next   = state;
      counter_next = counter;
      bx_next      = bx;
      by_next      = by;
      dx_next      = dx;
      dy_next      = dy;
      score1_next  = score1;
      score2_next  = score2;
      ov1       = (bys + BALL_S > p1s) && (bys < p1s + PADH_S);
      ov2       = (bys + BALL_S > p2s) && (bys < p2s + PADH_S);
      hit1      = !dx && (bxs >= LFACE_S) && (bxs - BSPD_S < LFACE_S) && ov1;
      hit2      = dx && (bxs + BALL_S <= RPADX0_S) && (bxs + BALL_S + BSPD_S > RPADX0_S) && ov2;
      miss      = dx ? (bxs > BXMAX_S - BSPD_S) : (bxs < BSPD_S);
      bx_step   = dx ? bxs + BSPD_S : bxs - BSPD_S;
      by_step   = dy ? bys + BSPD_S : bys - BSPD_S;
      new_score = dx ? score1 + 4'd1 : score2 + 4'd1;
      case (state)
         SERVE: begin
            bx_next = SX_S[9:0];
            by_next = SY_S[9:0];
            if (counter == CW'(SERVE_FRAMES - 1)) begin
               state_next   = PLAY;
               counter_next = '0;
            end else begin
               counter_next = counter + 1'b1;
            end
         end
         PLAY: begin
            if (!dy && bys < BSPD_S) begin
               by_next = '0;
               dy_next = 1'b1;
            end else if (dy && bys > BYMAX_S - BSPD_S) begin
               by_next = BYMAX_S[9:0];
               dy_next = 1'b0;
            end else begin
               by_next = by_step[9:0];
            end
            if (hit1) begin
               bx_next = LFACE_S[9:0];
               dx_next = 1'b1;
            end else if (hit2) begin
               bx_next = RHIT_S[9:0];
               dx_next = 1'b0;
            end else if (miss) begin
               state_next = POINT;
            end else begin
               bx_next = bx_step[9:0];
            end
         end
         POINT: begin
            counter_next = '0;
            bx_next      = SX_S[9:0];
            by_next      = SY_S[9:0];
            if (dx)
               score1_next = new_score;
            else
               score2_next = new_score;
            state_next = (new_score == 4'd9) ? GAMEOVER : SERVE;
         end
         default: begin
         end
      endcase
   end

`ifdef PONG_AUTO_PADDLE_EN
   logic signed [10:0] track_diff;
   always_comb begin
      track_diff = (bys + 11'(BALL / 2)) - (p2s + 11'(PAD_H / 2));
      pad1_next  = pad_step(pad1, bus.p1_up, bus.p1_down);
      pad2_next  = pad_step(pad2, track_diff < -PSPD_S, track_diff > PSPD_S);
   end
`else
   always_comb begin
      pad1_next = pad_step(pad1, bus.p1_up, bus.p1_down);
      pad2_next = pad_step(pad2, bus.p2_up, bus.p2_down);
   end
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         state   <= SERVE;
         counter <= '0;
         bx      <= SX_S[9:0];
         by      <= SY_S[9:0];
         dx      <= 1'b1;
         dy      <= 1'b1;
         pad1    <= PINIT_S[9:0];
         pad2    <= PINIT_S[9:0];
         score1  <= '0;
         score2  <= '0;
      end else if (frame_tick) begin
         state   <= state_next;
         counter <= counter_next;
         bx      <= bx_next;
         by      <= by_next;
         dx      <= dx_next;
         dy      <= dy_next;
         pad1    <= pad1_next;
         pad2    <= pad2_next;
         score1  <= score1_next;
         score2  <= score2_next;
      end
   end

   // Ball beats paddle beats centre line; the ball vanishes once the game is over.
   always_comb begin
      xs      = {1'b0, bus.xpos};
      ys      = {1'b0, bus.ypos};
      in_act  = (xs < XRES_S) && (ys < YRES_S);
      on_ball = (state != GAMEOVER) && (xs >= bxs) && (xs < bxs + BALL_S) &&
                (ys >= bys) && (ys < bys + BALL_S);
      on_pad  = ((xs >= LPADX0_S) && (xs <= LPADX1_S) && (ys >= p1s) && (ys < p1s + PADH_S)) ||
                ((xs >= RPADX0_S) && (xs <= RPADX1_S) && (ys >= p2s) && (ys < p2s + PADH_S));
      on_line = ((xs == CL0_S) || (xs == CL1_S)) && !bus.ypos[4];
      pixel   = 8'h00;
      if (in_act) begin
         if (on_ball)
            pixel = 8'hFF;
         else if (on_pad)
            pixel = 8'h1C;
         else if (on_line)
            pixel = 8'h92;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         rgb     <= 8'h00;
         hsync   <= 1'b1;
         vsync   <= 1'b1;
         vs_prev <= 1'b1;
      end else begin
         rgb     <= pixel;
         hsync   <= bus.hsync_in;
         vsync   <= bus.vsync_in;
         vs_prev <= bus.vsync_in;
      end
   end

   assign bus.rgb       = rgb;
   assign bus.hsync     = hsync;
   assign bus.vsync     = vsync;
   assign bus.score1    = score1;
   assign bus.score2    = score2;
   assign bus.game_over = (state == GAMEOVER);

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: pixel vector table plus frame-by-frame game sequences.
module tb_pong_frame_renderer;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic [7:0] rgb;
   } pix_vec_t;

   logic       clock;
   logic       reset;
   int         checks;
   int         failures;
   pix_vec_t   vecs [18];
   logic [7:0] prevRgb;
   logic       prevHs;

   pong_frame_renderer_if bus ();

   pong_frame_renderer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input pix_vec_t v);
      @(negedge clock);
      bus.xpos     = v.x;
      bus.ypos     = v.y;
      bus.hsync_in = v.hs;
      bus.vsync_in = v.vs;
   endtask

   // Holds reset low across exactly one rising edge and returns with it still low.
   task automatic resetDut();
      @(negedge clock);
      reset        = 1'b0;
      bus.vsync_in = 1'b1;
      bus.p1_up    = 1'b0;
      bus.p1_down  = 1'b0;
      bus.p2_up    = 1'b0;
      bus.p2_down  = 1'b0;
      @(negedge clock);
   endtask

   task automatic frameTicks(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         bus.vsync_in = 1'b0;
         @(negedge clock);
         bus.vsync_in = 1'b1;
      end
   endtask

   task automatic checkPixel(input string name, input logic [9:0] x, input logic [9:0] y, input logic [7:0] exp);
      pix_vec_t v;
      v = '{x, y, 1'b1, 1'b1, exp};
      applyStimulus(v);
      @(posedge clock);
      #1;
      checkOutput(name, int'(bus.rgb), int'(exp));
   endtask

   initial begin
      checks       = 0;
      failures     = 0;
      reset        = 1'b1;
      bus.xpos     = 10'd700;
      bus.ypos     = 10'd0;
      bus.hsync_in = 1'b1;
      bus.vsync_in = 1'b1;
      bus.p1_up    = 1'b0;
      bus.p1_down  = 1'b0;
      bus.p2_up    = 1'b0;
      bus.p2_down  = 1'b0;

      vecs[0]  = '{10'd316, 10'd236, 1'b1, 1'b1, 8'hFF};
      vecs[1]  = '{10'd323, 10'd243, 1'b1, 1'b1, 8'hFF};
      vecs[2]  = '{10'd324, 10'd236, 1'b0, 1'b1, 8'h00};
      vecs[3]  = '{10'd315, 10'd240, 1'b1, 1'b1, 8'h00};
      vecs[4]  = '{10'd316, 10'd244, 1'b1, 1'b1, 8'h00};
      vecs[5]  = '{10'd319, 10'd0,   1'b1, 1'b1, 8'h92};
      vecs[6]  = '{10'd320, 10'd16,  1'b1, 1'b1, 8'h00};
      vecs[7]  = '{10'd320, 10'd47,  1'b1, 1'b1, 8'h92};
      vecs[8]  = '{10'd16,  10'd208, 1'b0, 1'b1, 8'h1C};
      vecs[9]  = '{10'd623, 10'd271, 1'b1, 1'b1, 8'h1C};
      vecs[10] = '{10'd24,  10'd208, 1'b1, 1'b1, 8'h00};
      vecs[11] = '{10'd16,  10'd272, 1'b1, 1'b1, 8'h00};
      vecs[12] = '{10'd616, 10'd207, 1'b1, 1'b1, 8'h00};
      vecs[13] = '{10'd700, 10'd100, 1'b1, 1'b0, 8'h00};
      vecs[14] = '{10'd100, 10'd500, 1'b1, 1'b1, 8'h00};
      vecs[15] = '{10'd639, 10'd479, 1'b1, 1'b1, 8'h00};
      vecs[16] = '{10'd320, 10'd238, 1'b1, 1'b1, 8'hFF};
      vecs[17] = '{10'd318, 10'd0,   1'b1, 1'b1, 8'h00};

      repeat (2) @(negedge clock);

      // Reset values, then the pixel table with a one-clock latency check on each vector
      resetDut();
      checkOutput("reset rgb", int'(bus.rgb), 0);
      checkOutput("reset hsync", int'(bus.hsync), 1);
      checkOutput("reset vsync", int'(bus.vsync), 1);
      checkOutput("reset score1", int'(bus.score1), 0);
      checkOutput("reset score2", int'(bus.score2), 0);
      checkOutput("reset game_over", int'(bus.game_over), 0);
      checkOutput("reset bx", int'(dut.bx), 316);
      checkOutput("reset by", int'(dut.by), 236);
      checkOutput("reset dx", int'(dut.dx), 1);
      checkOutput("reset dy", int'(dut.dy), 1);
      checkOutput("reset pad1", int'(dut.pad1), 208);
      checkOutput("reset pad2", int'(dut.pad2), 208);
      reset   = 1'b1;
      prevRgb = 8'h00;
      prevHs  = 1'b1;
      for (int i = 0; i < 18; i++) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput($sformatf("vec%0d rgb before edge", i), int'(bus.rgb), int'(prevRgb));
         checkOutput($sformatf("vec%0d hsync before edge", i), int'(bus.hsync), int'(prevHs));
         @(posedge clock);
         #1;
         checkOutput($sformatf("vec%0d rgb", i), int'(bus.rgb), int'(vecs[i].rgb));
         checkOutput($sformatf("vec%0d hsync", i), int'(bus.hsync), int'(vecs[i].hs));
         checkOutput($sformatf("vec%0d vsync", i), int'(bus.vsync), int'(vecs[i].vs));
         prevRgb = vecs[i].rgb;
         prevHs  = vecs[i].hs;
      end

      // The table produced one frame tick; serve ends on tick 60, ball first moves on tick 61
      frameTicks(59);
      checkOutput("serve end bx", int'(dut.bx), 316);
      checkOutput("serve end by", int'(dut.by), 236);
      frameTicks(1);
      checkOutput("first play bx", int'(dut.bx), 318);
      checkOutput("first play by", int'(dut.by), 238);

      // Paddle 2 driven to the bottom so the ball bounces off its face at bx=608
      bus.p2_down = 1'b1;
      frameTicks(145);
      checkOutput("pre right face bx", int'(dut.bx), 608);
      checkOutput("pre right face by", int'(dut.by), 418);
      checkOutput("pad2 bottom clamp", int'(dut.pad2), 416);
      frameTicks(1);
      checkOutput("right face bx", int'(dut.bx), 608);
      checkOutput("right face dx", int'(dut.dx), 0);
      checkOutput("right face by", int'(dut.by), 416);
      bus.p2_down = 1'b0;

      frameTicks(207);
      checkOutput("top approach by", int'(dut.by), 2);
      checkOutput("top approach dy", int'(dut.dy), 0);
      frameTicks(1);
      checkOutput("top reach by", int'(dut.by), 0);
      checkOutput("top reach dy", int'(dut.dy), 0);
      frameTicks(1);
      checkOutput("top bounce by", int'(dut.by), 0);
      checkOutput("top bounce dy", int'(dut.dy), 1);

      bus.p1_up = 1'b1;
      frameTicks(10);
      bus.p1_up = 1'b0;
      checkOutput("pad1 raised", int'(dut.pad1), 168);
      frameTicks(73);
      checkOutput("pre left face bx", int'(dut.bx), 24);
      checkOutput("pre left face by", int'(dut.by), 166);
      frameTicks(1);
      checkOutput("left face bx", int'(dut.bx), 24);
      checkOutput("left face dx", int'(dut.dx), 1);
      checkOutput("left face by", int'(dut.by), 168);
      frameTicks(1);
      checkOutput("after left face bx", int'(dut.bx), 26);

      // Same rally with paddle 1 left in place: the ball slips past and player 2 scores
      resetDut();
      reset       = 1'b1;
      bus.p2_down = 1'b1;
      frameTicks(207);
      checkOutput("rally2 right face bx", int'(dut.bx), 608);
      checkOutput("rally2 right face dx", int'(dut.dx), 0);
      bus.p2_down = 1'b0;
      frameTicks(293);
      checkOutput("no overlap bx", int'(dut.bx), 22);
      checkOutput("no overlap dx", int'(dut.dx), 0);
      frameTicks(11);
      checkOutput("left edge bx", int'(dut.bx), 0);
      frameTicks(1);
      checkOutput("miss tick score2", int'(bus.score2), 0);
      frameTicks(1);
      checkOutput("point score2", int'(bus.score2), 1);
      checkOutput("point score1", int'(bus.score1), 0);
      checkOutput("point dx", int'(dut.dx), 0);
      checkOutput("point serve bx", int'(dut.bx), 316);
      checkOutput("point serve by", int'(dut.by), 236);
      checkOutput("point game_over", int'(bus.game_over), 0);

      // Paddle clamp at the top, then nine unanswered player 1 points (220 ticks each)
      resetDut();
      reset     = 1'b1;
      bus.p1_up = 1'b1;
      frameTicks(51);
      checkOutput("pad1 after 51", int'(dut.pad1), 4);
      frameTicks(1);
      checkOutput("pad1 after 52", int'(dut.pad1), 0);
      frameTicks(8);
      checkOutput("pad1 after 60", int'(dut.pad1), 0);
      bus.p1_down = 1'b1;
      frameTicks(3);
      checkOutput("pad1 both buttons", int'(dut.pad1), 0);
      bus.p1_up = 1'b0;
      frameTicks(1);
      checkOutput("pad1 down", int'(dut.pad1), 4);
      bus.p1_down = 1'b0;
      frameTicks(155);
      checkOutput("before point1 score1", int'(bus.score1), 0);
      frameTicks(1);
      checkOutput("point1 score1", int'(bus.score1), 1);
      frameTicks(1759);
      checkOutput("before final score1", int'(bus.score1), 8);
      checkOutput("before final game_over", int'(bus.game_over), 0);
      frameTicks(1);
      checkOutput("final score1", int'(bus.score1), 9);
      checkOutput("final game_over", int'(bus.game_over), 1);
      checkOutput("final score2", int'(bus.score2), 0);
      checkPixel("gameover ball hidden", 10'd316, 10'd236, 8'h00);
      checkPixel("gameover centre line", 10'd320, 10'd236, 8'h92);
      checkPixel("gameover paddle1", 10'd16, 10'd4, 8'h1C);
      bus.p1_down = 1'b1;
      frameTicks(5);
      bus.p1_down = 1'b0;
      checkOutput("gameover pad1 moves", int'(dut.pad1), 24);
      checkOutput("gameover score1 held", int'(bus.score1), 9);
      checkOutput("gameover held", int'(bus.game_over), 1);

      @(negedge clock);
      bus.xpos     = 10'd316;
      bus.ypos     = 10'd236;
      bus.hsync_in = 1'b0;
      resetDut();
      checkOutput("final reset rgb", int'(bus.rgb), 0);
      checkOutput("final reset hsync", int'(bus.hsync), 1);
      checkOutput("final reset vsync", int'(bus.vsync), 1);
      checkOutput("final reset score1", int'(bus.score1), 0);
      checkOutput("final reset score2", int'(bus.score2), 0);
      checkOutput("final reset game_over", int'(bus.game_over), 0);
      checkOutput("final reset pad1", int'(dut.pad1), 208);
      checkOutput("final reset bx", int'(dut.bx), 316);
      reset = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
